// File: rtl/reg36_pkg.sv
// Shared types and constants for the reg36 access controller.
package reg36_pkg;

    // Default data width of the reg36 register
    localparam int unsigned REG36_WIDTH = 36;

    // Requester operation codes
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } op_e;

    // Transaction sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_ACK    = 3'd4
    } state_e;

endpackage : reg36_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  winner_o,
    output logic             any_o
);

    logic found;

    // Scan distances 0..NREQ-1 from the pointer; the nearest active requester wins
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req_i[i] && (i == (32'(ptr_i) + k) % NREQ)) begin
                    winner_o[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    assign any_o = |req_i;

endmodule : rr_arbiter

// File: rtl/reg36_access_ctrl.sv
// Shares the reg36 register between NREQ requesters: round-robin grant, latched op/data,
// one setup cycle, a single-cycle set/inc/dec strobe, then an ack with the post-op value.
module reg36_access_ctrl
    import reg36_pkg::*;
#(
    parameter int unsigned WIDTH = REG36_WIDTH,
    parameter int unsigned NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  reg_set,
    output logic                  reg_inc,
    output logic                  reg_dec,
    input  logic [WIDTH-1:0]      reg_q
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_nxt;
    op_e                op_q;
    logic [WIDTH-1:0]   reg_d_q;
    logic [WIDTH-1:0]   rdata_q;

    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               set_q, set_d;
    logic               inc_q, inc_d;
    logic               dec_q, dec_d;

    logic [NREQ-1:0]    winner;
    logic               any;
    logic [1:0]         op_sel;
    logic [WIDTH-1:0]   din_sel;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any)
    );

    // Select the winning requester's op and data slices
    always_comb begin
        op_sel  = '0;
        din_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
                op_sel  = op_sel  | op[2*i +: 2];
                din_sel = din_sel | din[WIDTH*i +: WIDTH];
            end
        end
    end

    // Pointer value following the current grant holder, modulo NREQ
    always_comb begin
        ptr_nxt = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                ptr_nxt = PTR_W'((i + 1) % NREQ);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: fixed five-cycle walk once any request is seen in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any) state_d = ST_GRANT;
            ST_GRANT:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: decoded from the next state so that every output is registered
    always_comb begin
        gnt_d  = '0;
        ack_d  = '0;
        set_d  = 1'b0;
        inc_d  = 1'b0;
        dec_d  = 1'b0;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_GRANT: gnt_d = winner;
            ST_SETUP: gnt_d = gnt_q;
            ST_STROBE: begin
                gnt_d = gnt_q;
                case (op_q)
                    OP_LOAD: set_d = 1'b1;
                    OP_INC:  inc_d = 1'b1;
                    OP_DEC:  dec_d = 1'b1;
                    default: ;
                endcase
            end
            ST_ACK: begin
                gnt_d = gnt_q;
                ack_d = gnt_q;
            end
            default: ;
        endcase
    end

    // Registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            ack_q  <= '0;
            busy_q <= 1'b0;
            set_q  <= 1'b0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            ack_q  <= ack_d;
            busy_q <= busy_d;
            set_q  <= set_d;
            inc_q  <= inc_d;
            dec_q  <= dec_d;
        end
    end

    // Latch the winner's op and data on entry to GRANT; later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_NOP;
            reg_d_q <= '0;
        end else if (state_q == ST_IDLE && any) begin
            op_q    <= op_e'(op_sel);
            reg_d_q <= din_sel;
        end
    end

    // reg36 has updated by the ACK cycle; capture Q and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            ptr_q   <= '0;
        end else if (state_q == ST_ACK) begin
            rdata_q <= reg_q;
            ptr_q   <= ptr_nxt;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign reg_set = set_q;
    assign reg_inc = inc_q;
    assign reg_dec = dec_q;
    assign reg_d   = reg_d_q;
    assign rdata   = rdata_q;

endmodule : reg36_access_ctrl

// File: tb/tb_reg36_access_ctrl.sv
// Self-checking bench for reg36_access_ctrl with a behavioural reg36 and transaction model.
module tb_reg36_access_ctrl;

    localparam int W = 36;
    localparam int N = 3;
    localparam logic [W-1:0] MASK = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [2*N-1:0]   op = '0;
    logic [W*N-1:0]   din = '0;
    logic [N-1:0]     gnt, ack;
    logic [W-1:0]     rdata, reg_d, reg_q;
    logic             busy, reg_set, reg_inc, reg_dec;

    logic [W-1:0]     r36_q = '0;
    logic             r36_clr = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference-model state
    logic [W-1:0] m_q;
    int           m_ptr;

    always #5 clk = ~clk;

    // Behavioural reg36
    always @(posedge clk) begin
        if (r36_clr)      r36_q <= '0;
        else if (reg_set) r36_q <= reg_d;
        else if (reg_inc) r36_q <= r36_q + 1'b1;
        else if (reg_dec) r36_q <= r36_q - 1'b1;
    end
    assign reg_q = r36_q;

    reg36_access_ctrl #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .din(din),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .reg_d(reg_d), .reg_set(reg_set), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_q(reg_q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_stb(input logic [1:0] o);
        case (o)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [W-1:0] apply_op(input logic [W-1:0] q, input logic [1:0] o,
                                              input logic [W-1:0] d);
        case (o)
            2'b01:   return d;
            2'b10:   return (q + 1) & MASK;
            2'b11:   return (q - 1) & MASK;
            default: return q;
        endcase
    endfunction

    function automatic int rr_pick(input logic [N-1:0] pend, input int p);
        for (int k = 0; k < N; k++)
            if (pend[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // One request from requester r; optional drop after GRANT and din change in STROBE
    task automatic run_single(input string name, input int r, input logic [1:0] o,
                              input logic [W-1:0] d, input bit drop, input bit chg);
        logic [N-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        req[r] = 1'b1;
        op[2*r +: 2] = o;
        din[W*r +: W] = d;
        step();
        chk({name, "_gnt"}, gnt, oh);
        chk({name, "_busy"}, busy, 1);
        if (drop) req[r] = 1'b0;
        step();
        chk({name, "_setup_stb"}, {reg_set, reg_inc, reg_dec}, 0);
        if (o == 2'b01) chk({name, "_setup_d"}, reg_d, d);
        step();
        chk({name, "_stb"}, {reg_set, reg_inc, reg_dec}, exp_stb(o));
        if (chg) din[W*r +: W] = ~d;
        if (o == 2'b01) chk({name, "_stb_d"}, reg_d, d);
        step();
        chk({name, "_ack"}, ack, oh);
        chk({name, "_ack_stb"}, {reg_set, reg_inc, reg_dec}, 0);
        req[r] = 1'b0;
        m_q = apply_op(m_q, o, d);
        m_ptr = (r + 1) % N;
        step();
        chk({name, "_rdata"}, rdata, m_q);
        chk({name, "_idle"}, {busy, gnt, ack}, 0);
    endtask

    initial begin
        logic [N-1:0] pend, oh;
        logic [1:0]   o_w;
        logic [W-1:0] d_w;
        logic [2:0]   seen;
        int           w, nstb, lat;
        bit           got;

        // Reset state
        step();
        step();
        chk("rst_outs", {gnt, ack, busy, reg_set, reg_inc, reg_dec}, 0);
        chk("rst_reg_d", reg_d, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        r36_clr = 1'b0;
        m_q = '0;
        m_ptr = 0;
        step();

        // Reset during STROBE of a LOAD aborts it
        req[0] = 1'b1;
        op[1:0] = 2'b01;
        din[W-1:0] = 36'h1_2345_6789;
        step(); step(); step();
        chk("abort_pre_set", reg_set, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_set_drop", {reg_set, reg_inc, reg_dec}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gnt_ack", {gnt, ack}, 0);
        chk("abort_rdata", rdata, 0);
        req = '0;
        step();
        chk("abort_no_load", reg_q, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("abort_no_ack", ack, 0);
        end

        // Directed single transactions
        run_single("load", 0, 2'b01, 36'h9_ABCD_1234, 0, 0);
        run_single("ldmax", 1, 2'b01, 36'hF_FFFF_FFFF, 0, 0);
        run_single("incwrap", 2, 2'b10, '0, 0, 0);
        chk("incwrap_val", rdata, 0);
        run_single("decwrap", 0, 2'b11, '0, 0, 0);
        chk("decwrap_val", rdata, 36'hF_FFFF_FFFF);
        run_single("nop", 1, 2'b00, 36'h0_1111_2222, 0, 0);
        run_single("cancel", 2, 2'b10, '0, 1, 0);
        run_single("hold", 0, 2'b01, 36'h5_5555_AAAA, 0, 1);
        chk("hold_val", rdata, 36'h5_5555_AAAA);

        // Round-robin from a fresh reset with all three requesting INC
        rst_n = 1'b0;
        r36_clr = 1'b1;
        step();
        rst_n = 1'b1;
        r36_clr = 1'b0;
        m_q = '0;
        m_ptr = 0;
        step();
        req = '1;
        op = {2'b10, 2'b10, 2'b10};
        step(); step(); step(); step();
        for (int t = 0; t < 6; t++) begin
            oh = '0;
            oh[t % N] = 1'b1;
            chk("rr_ack", ack, oh);
            step();
            chk("rr_rdata", rdata, 36'(t + 1));
            if (t < 5) begin
                chk("rr_gap_ack", ack, 0);
                step(); step(); step(); step();
            end
        end
        req = '0;
        step();
        m_q = 36'd6;
        m_ptr = 0;

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                op[2*i +: 2] = 2'($urandom_range(0, 3));
                din[W*i +: W] = W'({$urandom(), $urandom()});
            end
            req = pend;
            w = rr_pick(pend, m_ptr);
            o_w = op[2*w +: 2];
            d_w = din[W*w +: W];
            oh = '0;
            oh[w] = 1'b1;
            got = 0;
            seen = '0;
            nstb = 0;
            lat = 0;
            for (int c = 1; c <= 12 && !got; c++) begin
                step();
                chk("rnd_stb_excl", ($countones({reg_set, reg_inc, reg_dec}) <= 1), 1);
                if ({reg_set, reg_inc, reg_dec} != 0) begin
                    seen = {reg_set, reg_inc, reg_dec};
                    nstb++;
                end
                if (ack != 0) begin
                    got = 1;
                    lat = c;
                end
            end
            chk("rnd_ack_seen", got, 1);
            chk("rnd_latency", lat, 4);
            chk("rnd_ack", ack, oh);
            chk("rnd_stb", seen, exp_stb(o_w));
            chk("rnd_nstb", nstb, (o_w != 2'b00) ? 1 : 0);
            req = '0;
            m_q = apply_op(m_q, o_w, d_w);
            m_ptr = (w + 1) % N;
            step();
            chk("rnd_rdata", rdata, m_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_reg36_access_ctrl
